// File: rtl/fxp_seq_mult.sv
// Iterative signed fixed-point multiplier (shift-add, one partial product per cycle) with
// saturation and overflow flag. Define FXP_MULT_ROUND_EN to round half away from zero.
module fxp_seq_mult #(
    parameter int INT_W = 16,
    parameter int FRAC_W = 16,
    localparam int W = INT_W + FRAC_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic [2*W-1:0] product_full,
    output logic           overflow
);
    localparam int CW = $clog2(W);
    localparam logic [2*W:0] POS_LIM = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic [2*W:0] NEG_LIM = POS_LIM + 1'b1;
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
    state_t state, state_nx;

    logic          sign;
    logic [W-1:0]  mcand, mult, acc_hi;
    logic [CW-1:0] cnt;
    logic [W:0]    sum;
    logic [2*W-1:0] p;
    logic [2*W:0]  p_adj, m;
    logic [W-1:0]  m_lo, res_nx;
    logic          ovf_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = CALC;
            CALC: if (cnt == CW'(W-1)) state_nx = NORM;
            NORM: state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Carry out of the add lands in the top bit before the joint right shift.
    assign sum = {1'b0, acc_hi} + {1'b0, (mult[0] ? mcand : {W{1'b0}})};
    assign p   = {acc_hi, mult};

`ifdef FXP_MULT_ROUND_EN
    assign p_adj = {1'b0, p} + ({{(2*W){1'b0}}, 1'b1} << (FRAC_W-1));
`else
    assign p_adj = {1'b0, p};
`endif
    assign m    = p_adj >> FRAC_W;
    assign m_lo = m[W-1:0];

    always_comb begin
        res_nx = sign ? -m_lo : m_lo;
        ovf_nx = 1'b0;
        if (!sign && m > POS_LIM) begin
            res_nx = SAT_MAX;
            ovf_nx = 1'b1;
        end else if (sign && m > NEG_LIM) begin
            res_nx = SAT_MIN;
            ovf_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign         <= 1'b0;
            mcand        <= '0;
            mult         <= '0;
            acc_hi       <= '0;
            cnt          <= '0;
            result       <= '0;
            product_full <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign   <= a[W-1] ^ b[W-1];
                    mcand  <= a[W-1] ? -a : a;
                    mult   <= b[W-1] ? -b : b;
                    acc_hi <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    acc_hi <= sum[W:1];
                    mult   <= {sum[0], mult[W-1:1]};
                    cnt    <= cnt + CW'(1);
                end
                NORM: begin
                    product_full <= sign ? -p : p;
                    result       <= res_nx;
                    overflow     <= ovf_nx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fxp_seq_mult.sv
// Randomized self-checking bench for fxp_seq_mult against a plain-arithmetic product model.
module tb_fxp_seq_mult;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0, b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [63:0] product_full;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_res;
    logic [63:0] exp_pf;
    logic        exp_ovf;
    logic        exp_live = 1'b0;

    fxp_seq_mult dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .product_full(product_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // Q16.16 reference using 64-bit signed arithmetic.
    task automatic model(input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic [63:0] pf, output logic o);
        longint prod, mag, mq;
        prod = longint'($signed(x)) * longint'($signed(y));
        mag  = (prod < 0) ? -prod : prod;
`ifdef FXP_MULT_ROUND_EN
        mq = (mag + 64'sd32768) >>> 16;
`else
        mq = mag >>> 16;
`endif
        pf = prod;
        o  = 1'b0;
        if (prod >= 0 && mq > 64'sd2147483647) begin
            r = 32'h7FFF_FFFF; o = 1'b1;
        end else if (prod < 0 && mq > 64'sd2147483648) begin
            r = 32'h8000_0000; o = 1'b1;
        end else begin
            r = (prod < 0) ? 32'(-mq) : 32'(mq);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && exp_live) begin
            chk("result", {32'h0, result}, {32'h0, exp_res});
            chk("product_full", product_full, exp_pf);
            chk("overflow", {63'h0, overflow}, {63'h0, exp_ovf});
        end
    end

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int hold, input bit pulse);
        int edges;
        @(negedge clk);
        chk("in_ready_idle", {63'h0, in_ready}, 64'h1);
        model(x, y, exp_res, exp_pf, exp_ovf);
        exp_live = 1'b1;
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom;
        edges = 0;
        while (!out_valid && edges < 100) begin
            if (pulse && edges == 3) begin
                in_valid = 1'b1; a = $urandom; b = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(edges), 64'd33);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_in_ready", {63'h0, in_ready}, 64'h0);
            chk("hold_out_valid", {63'h0, out_valid}, 64'h1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("drain_out_valid", {63'h0, out_valid}, 64'h0);
        chk("drain_in_ready", {63'h0, in_ready}, 64'h1);
    endtask

    task automatic pin(input string nm, input logic [31:0] r, input logic [63:0] pf, input logic o);
        chk({nm, "_res"}, {32'h0, result}, {32'h0, r});
        chk({nm, "_pf"}, product_full, pf);
        chk({nm, "_ovf"}, {63'h0, overflow}, {63'h0, o});
    endtask

    initial begin
        logic [31:0] x, y;
        #12;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_result", {32'h0, result}, 64'h0);
        chk("rst_pf", product_full, 64'h0);
        chk("rst_ovf", {63'h0, overflow}, 64'h0);
        rst_n = 1'b1;

        do_op(32'h0001_8000, 32'h0003_4000, 0, 0);
        pin("t1", 32'h0004_E000, 64'h0000_0004_E000_0000, 1'b0);
        do_op(32'hFFFE_8000, 32'h0003_4000, 0, 0);
        pin("t2neg", 32'hFFFB_2000, 64'hFFFF_FFFB_2000_0000, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 0, 0);
        pin("t2min", 32'h7FFF_FFFF, 64'h4000_0000_0000_0000, 1'b1);
        do_op(32'h7FFF_0000, 32'h0002_0000, 0, 0);
        pin("t3pos", 32'h7FFF_FFFF, 64'h0000_FFFE_0000_0000, 1'b1);
        do_op(32'h8000_0000, 32'h0002_0000, 0, 0);
        pin("t3neg", 32'h8000_0000, 64'hFFFF_0000_0000_0000, 1'b1);
        do_op(32'h4000_0000, 32'hFFFE_0000, 0, 0);
        pin("t3edge", 32'h8000_0000, 64'hFFFF_8000_0000_0000, 1'b0);
        do_op(32'h0000_0001, 32'h0000_8000, 0, 0);
`ifdef FXP_MULT_ROUND_EN
        pin("t4", 32'h0000_0001, 64'h0000_0000_0000_8000, 1'b0);
`else
        pin("t4", 32'h0000_0000, 64'h0000_0000_0000_8000, 1'b0);
`endif
        do_op(32'h0002_0000, 32'hFFFF_8000, 5, 1);
        pin("t5", 32'hFFFF_0000, 64'hFFFF_FFFF_0000_0000, 1'b0);

        // Abort mid-CALC with an asynchronous reset.
        exp_live = 1'b0;
        @(negedge clk);
        a = 32'h0001_8000; b = 32'h0003_4000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", {63'h0, in_ready}, 64'h1);
        chk("arst_out_valid", {63'h0, out_valid}, 64'h0);
        chk("arst_result", {32'h0, result}, 64'h0);
        chk("arst_pf", product_full, 64'h0);
        chk("arst_ovf", {63'h0, overflow}, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        do_op(32'h0001_8000, 32'h0003_4000, 0, 0);
        pin("t6", 32'h0004_E000, 64'h0000_0004_E000_0000, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(3))
                0: begin x = $urandom; y = $urandom; end
                1: begin x = 32'($signed(20'($urandom))); y = 32'($signed(20'($urandom))); end
                2: begin x = 32'($signed(28'($urandom))); y = 32'($signed(24'($urandom))); end
                default: begin x = 32'($signed(16'($urandom))); y = $urandom; end
            endcase
            do_op(x, y, $urandom_range(2), $urandom_range(1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
